// File: rtl/pcie_phy_pkg.sv
// Shared PCIe physical-layer types: special symbols, training-set identifiers,
// the captured TS1/TS2 ordered-set layout and the TS receiver FSM states.
package pcie_phy_pkg;

  typedef enum logic [7:0] {
    COM = 8'hBC,  // K28.5
    STP = 8'hFB,  // K27.7
    SDP = 8'h5C,  // K28.2
    EDB = 8'hFE,  // K30.7
    PAD = 8'hF7,  // K23.7
    SKP = 8'h1C,  // K28.0
    FTS = 8'h3C,  // K28.1
    IDL = 8'h7C,  // K28.3
    EIE = 8'hFC   // K28.7
  } phy_layer_special_symbols_e;

  typedef enum logic [7:0] {
    TS1 = 8'h4A,
    TS2 = 8'h45
  } train_seq_e;

  // Symbol 0 sits in the MSBs; ts_id[k] holds symbol 6+k.
  typedef struct packed {
    logic [7:0]       com;
    logic [7:0]       link;
    logic [7:0]       lane;
    logic [7:0]       n_fts;
    logic [7:0]       rate;
    logic [7:0]       train_ctl;
    logic [9:0][7:0]  ts_id;
  } pcie_tsos_t;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    DONE
  } tsos_rx_state_e;

endpackage

// File: rtl/pcie_tsos_rx.sv
// TS1/TS2 ordered-set receiver for one gen1/gen2 lane: aligns on COM, checks
// each symbol, captures the set and counts consecutive identical sets.
module pcie_tsos_rx
  import pcie_phy_pkg::*;
#(
  parameter int CONSEC_TARGET = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_datak_i,
  input  logic             rx_valid_i,
  output logic             ts_valid_o,
  output logic             ts_type_o,
  output pcie_tsos_t       ts_o,
  output logic [CNT_W-1:0] consec_cnt_o,
  output logic             consec_met_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Two sets are identical when type and symbols 1..5 agree.
  function automatic logic same_ts(input pcie_tsos_t a, input pcie_tsos_t b);
    return (a.ts_id[0] == b.ts_id[0]) && (a.link == b.link) && (a.lane == b.lane) &&
           (a.n_fts == b.n_fts) && (a.rate == b.rate) && (a.train_ctl == b.train_ctl);
  endfunction

  tsos_rx_state_e    state_q;
  logic [3:0]        idx_q;
  logic [14:0][7:0]  sym_q;

  logic              is_com;
  logic              sym_ok;
  pcie_tsos_t        new_ts;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    is_com = rx_datak_i && (rx_data_i == COM);
    sym_ok = 1'b0;
    if (idx_q == 4'd1 || idx_q == 4'd2)
      sym_ok = !rx_datak_i || (rx_data_i == PAD);
    else if (idx_q >= 4'd3 && idx_q <= 4'd5)
      sym_ok = !rx_datak_i;
    else if (idx_q == 4'd6)
      sym_ok = !rx_datak_i && (rx_data_i == TS1 || rx_data_i == TS2);
    else
      sym_ok = !rx_datak_i && (rx_data_i == sym_q[6]);

    // Symbol 15 is still on the bus when the set completes.
    new_ts           = '0;
    new_ts.com       = sym_q[0];
    new_ts.link      = sym_q[1];
    new_ts.lane      = sym_q[2];
    new_ts.n_fts     = sym_q[3];
    new_ts.rate      = sym_q[4];
    new_ts.train_ctl = sym_q[5];
    for (int j = 0; j < 9; j++) new_ts.ts_id[j] = sym_q[6+j];
    new_ts.ts_id[9]  = rx_data_i;

    cnt_nxt = CNT_ONE;
    if (same_ts(new_ts, ts_o))
      cnt_nxt = (consec_cnt_o == CNT_MAX) ? CNT_MAX : consec_cnt_o + CNT_ONE;
  end

  // rx_valid_i qualifies rx_data_i/rx_datak_i each cycle; when low nothing
  // advances and the symbol is dropped (there is no backpressure).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= HUNT;
      idx_q        <= '0;
      sym_q        <= '0;
      ts_o         <= '0;
      ts_type_o    <= 1'b0;
      ts_valid_o   <= 1'b0;
      err_o        <= 1'b0;
      consec_cnt_o <= '0;
      consec_met_o <= 1'b0;
    end else begin
      ts_valid_o <= 1'b0;
      err_o      <= 1'b0;
      if (rx_valid_i) begin
        case (state_q)
          COLLECT: begin
            if (sym_ok) begin
              if (idx_q == 4'd15) begin
                state_q      <= DONE;
                idx_q        <= '0;
                ts_o         <= new_ts;
                ts_type_o    <= (sym_q[6] == TS2);
                ts_valid_o   <= 1'b1;
                consec_cnt_o <= cnt_nxt;
                consec_met_o <= (int'(cnt_nxt) >= CONSEC_TARGET);
              end else begin
                sym_q[idx_q] <= rx_data_i;
                idx_q        <= idx_q + 4'd1;
              end
            end else begin
              err_o        <= 1'b1;
              consec_cnt_o <= '0;
              consec_met_o <= 1'b0;
              // A COM in the middle of a set starts the next set right away.
              if (is_com) begin
                sym_q[0] <= rx_data_i;
                idx_q    <= 4'd1;
                state_q  <= COLLECT;
              end else begin
                idx_q    <= '0;
                state_q  <= HUNT;
              end
            end
          end
          default: begin
            if (is_com) begin
              sym_q[0] <= rx_data_i;
              idx_q    <= 4'd1;
              state_q  <= COLLECT;
            end else begin
              idx_q    <= '0;
              state_q  <= HUNT;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcie_tsos_rx.sv
// Randomised bench for pcie_tsos_rx: frame-level reference model feeds an
// expected-event queue that a negedge monitor drains against the DUT pulses.
module tb_pcie_tsos_rx;
  import pcie_phy_pkg::*;

  localparam int CNT_W  = 4;
  localparam int TARGET = 8;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam int EW     = 1 + 1 + CNT_W + 1 + 32 + 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]       rx_data = '0;
  logic             rx_datak = 1'b0;
  logic             rx_valid = 1'b0;
  logic             ts_valid, ts_type, consec_met, err;
  pcie_tsos_t       ts;
  logic [CNT_W-1:0] consec_cnt;

  pcie_tsos_rx #(.CONSEC_TARGET(TARGET), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_datak_i  (rx_datak),
    .rx_valid_i  (rx_valid),
    .ts_valid_o  (ts_valid),
    .ts_type_o   (ts_type),
    .ts_o        (ts),
    .consec_cnt_o(consec_cnt),
    .consec_met_o(consec_met),
    .err_o       (err)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] fd[16];
  logic       fk[16];
  logic [47:0] last_sig = '0;
  bit         last_valid = 0;
  int         model_cnt = 0;
  bit         pending_com = 0;

  task automatic make_ts(input logic [7:0] ty, input logic [7:0] link, input logic link_k,
                         input logic [7:0] lane, input logic lane_k, input logic [7:0] nfts,
                         input logic [7:0] rate, input logic [7:0] ctl);
    fd[0] = COM;  fk[0] = 1'b1;
    fd[1] = link; fk[1] = link_k;
    fd[2] = lane; fk[2] = lane_k;
    fd[3] = nfts; fk[3] = 1'b0;
    fd[4] = rate; fk[4] = 1'b0;
    fd[5] = ctl;  fk[5] = 1'b0;
    for (int j = 6; j < 16; j++) begin
      fd[j] = ty;
      fk[j] = 1'b0;
    end
  endtask

  task automatic push_exp(input logic is_err, input logic ty, input int cnt, input pcie_tsos_t t);
    logic [EW-1:0] e;
    e = {is_err, ty, CNT_W'(cnt), (cnt >= TARGET), 32'(cyc + 1), t};
    exp_q.push_back(e);
  endtask

  task automatic accept_good();
    logic [47:0] sig;
    pcie_tsos_t  t;
    sig = {fd[6], fd[1], fd[2], fd[3], fd[4], fd[5]};
    if (last_valid && sig == last_sig) model_cnt = (model_cnt < SAT) ? model_cnt + 1 : SAT;
    else model_cnt = 1;
    last_sig   = sig;
    last_valid = 1;
    t           = '0;
    t.com       = 8'hBC;
    t.link      = fd[1];
    t.lane      = fd[2];
    t.n_fts     = fd[3];
    t.rate      = fd[4];
    t.train_ctl = fd[5];
    for (int j = 0; j < 10; j++) t.ts_id[j] = fd[6];
    push_exp(1'b0, (fd[6] == 8'h45), model_cnt, t);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic k);
    rx_valid = v;
    rx_data  = d;
    rx_datak = k;
    @(posedge clk);
    #1;
  endtask

  // mode 0: back-to-back, 1: idle cycle before every symbol, 2: random idles
  task automatic gap(input int mode);
    logic [7:0] jd;
    if (mode == 1 || (mode == 2 && $urandom_range(0, 99) < 30)) begin
      jd = ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom);
      drive(1'b0, jd, 1'($urandom));
    end
  endtask

  task automatic send_frame(input int mode, input int bad_at, input logic [7:0] bad_d, input logic bad_k);
    int start;
    bit errored;
    start = pending_com ? 1 : 0;
    pending_com = 0;
    errored = 0;
    for (int i = start; i < 16; i++) begin
      gap(mode);
      if (i == bad_at) begin
        push_exp(1'b1, 1'b0, 0, '0);
        model_cnt = 0;
        drive(1'b1, bad_d, bad_k);
        errored = 1;
        if (bad_k && bad_d == 8'hBC) begin
          pending_com = 1;
          return;
        end
      end else begin
        if (i == 15 && !errored) accept_good();
        drive(1'b1, fd[i], fk[i]);
      end
    end
  endtask

  task automatic idle_syms(input int n);
    for (int i = 0; i < n; i++)
      if ($urandom_range(0, 1) == 0) drive(1'b1, 8'hF7, 1'b1);
      else drive(1'b1, 8'($urandom_range(0, 8'hBB)), 1'b0);
  endtask

  task automatic model_reset();
    model_cnt   = 0;
    last_valid  = 0;
    pending_com = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ts_valid"}, ts_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_consec_cnt"}, consec_cnt, 0);
    check({tag, "_consec_met"}, consec_met, 0);
    check({tag, "_ts_type"}, ts_type, 0);
    check({tag, "_ts_o"}, ts, 0);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] me;
  always @(negedge clk) begin
    if (rst_n && (ts_valid || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {ts_valid, err}, 0);
      end else begin
        me = exp_q.pop_front();
        check("pulse_kind", {ts_valid, err}, me[EW-1] ? 128'd1 : 128'd2);
        check("pulse_cycle", cyc, me[159:128]);
        check("consec_cnt", consec_cnt, me[EW-3 -: CNT_W]);
        check("consec_met", consec_met, me[EW-3-CNT_W]);
        if (!me[EW-1]) begin
          check("ts_type", ts_type, me[EW-2]);
          check("ts_o", ts, me[127:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int tpl, mode, r, p;
    logic [7:0] bd;
    logic bk;

    rst_n = 1'b0;
    #12;
    check_zero("reset");
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Eight identical TS1 back-to-back, then on into saturation.
    make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    repeat (8) send_frame(0, -1, 8'h00, 1'b0);
    repeat (10) send_frame(0, -1, 8'h00, 1'b0);

    // Break the run, then the same TS1 stream with an idle every other cycle.
    make_ts(8'h45, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    send_frame(0, -1, 8'h00, 1'b0);
    make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    repeat (8) send_frame(1, -1, 8'h00, 1'b0);

    // Seven TS1 then a TS2 with identical fields.
    make_ts(8'h45, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    send_frame(0, -1, 8'h00, 1'b0);
    make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    repeat (7) send_frame(0, -1, 8'h00, 1'b0);
    make_ts(8'h45, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    send_frame(0, -1, 8'h00, 1'b0);

    // Bad symbol 9, then a good TS1.
    make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    send_frame(0, 9, 8'h45, 1'b0);
    send_frame(0, -1, 8'h00, 1'b0);

    // COM at symbol 10 restarts into a full TS2.
    send_frame(0, 10, 8'hBC, 1'b1);
    make_ts(8'h45, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    send_frame(0, -1, 8'h00, 1'b0);

    // Randomised mix of templates, gaps, corruptions and restarts.
    for (int n = 0; n < 60; n++) begin
      tpl = $urandom_range(0, 3);
      case (tpl)
        0: make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
        1: make_ts(8'h4A, 8'h01, 1'b0, 8'h03, 1'b0, 8'h20, 8'h06, 8'h00);
        2: make_ts(8'h45, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
        default: make_ts($urandom_range(0, 1) ? 8'h4A : 8'h45, 8'($urandom), 1'b0,
                         8'($urandom), 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      endcase
      mode = $urandom_range(0, 2);
      r = $urandom_range(0, 99);
      p = $urandom_range(1, 15);
      if (pending_com && p == 0) p = 1;
      if (r < 12) begin
        send_frame(mode, p, 8'hBC, 1'b1);
      end else if (r < 26) begin
        if (p <= 2) begin
          bd = $urandom_range(0, 1) ? 8'h3C : 8'h1C; bk = 1'b1;
        end else if (p <= 5) begin
          bd = $urandom_range(0, 1) ? 8'hF7 : 8'h3C; bk = 1'b1;
        end else if (p == 6) begin
          bd = 8'($urandom);
          if (bd == 8'h4A || bd == 8'h45) bd = 8'h00;
          bk = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          bd = (fd[6] == 8'h4A) ? 8'h45 : 8'h4A; bk = 1'b0;
        end else begin
          bd = fd[6]; bk = 1'b1;
        end
        send_frame(mode, p, bd, bk);
      end else begin
        send_frame(mode, -1, 8'h00, 1'b0);
      end
      if (!pending_com && $urandom_range(0, 3) == 0) idle_syms($urandom_range(1, 4));
    end
    if (pending_com) begin
      make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
      send_frame(0, -1, 8'h00, 1'b0);
    end

    // Reset in the middle of a set, then a clean TS1.
    make_ts(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1, 8'h10, 8'h02, 8'h00);
    repeat (2) send_frame(0, -1, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, fd[i], fk[i]);
    rx_valid = 1'b1;
    rx_data  = fd[7];
    rx_datak = fk[7];
    #2 rst_n = 1'b0;
    #1 check_zero("midset_reset");
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    send_frame(0, -1, 8'h00, 1'b0);

    repeat (6) drive(1'b0, 8'h00, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
